det_scheduler: RTL and testbench
================================

Name: det_scheduler

Overview:
- Controller that shares one combinational-plus-register 5x5 determinant datapath between two requesters.
- Arbitrates requests round-robin, configures the datapath input by padding NxN matrices (N=1..5) into 5x5 with identity, and waits the fixed datapath latency.
- Captures det/overflow and returns the result to the granted requester over a valid/ready response channel.
- Sits between the coprocessor instruction front-ends and the determinant datapath.

Parameters:
- DP_LATENCY, 2, cycles from dp_matrix stable to dp_det/dp_overflow valid (>=1).
- W, 8, element and result width (signed two's complement).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 request
- req0_ready  out  1  requester 0 accept (handshake when valid&ready)
- req0_size  in  3  matrix order N
- req0_matrix  in  25*W  element (r,c) at [(5r+c)*W +: W]
- req1_valid, req1_ready, req1_size, req1_matrix  same as requester 0
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 consumes result
- resp0_det  out  W  determinant low W bits
- resp0_overflow  out  1  result outside signed W range
- resp0_error  out  1  invalid size
- resp1_valid, resp1_ready, resp1_det, resp1_overflow, resp1_error  same for requester 1
- dp_matrix  out  25*W  registered datapath input
- dp_det  in  W  datapath result
- dp_overflow  in  1  datapath overflow
- busy  out  1  state != IDLE
- ops_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all ready/resp_valid=0; resp_det=0; overflow/error=0; dp_matrix=0; priority pointer=0 (req0 favoured); ops_count=0. Reset in any state aborts the in-flight operation; the result is dropped and no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester named by the pointer.
  - reqX_ready is combinational: 1 only when state==IDLE and X is granted. At most one ready is high per cycle.
- On handshake (IDLE, valid&ready):
  - Latch grant id.
  - Size valid (1..5): load dp_matrix with element (r,c) = reqX_matrix element if r<N and c<N; 1 if r==c>=N; 0 otherwise. Load counter=DP_LATENCY and go to WAIT.
  - Size invalid (0,6,7): leave dp_matrix unchanged, set result det=0, overflow=0, error=1, and go to RESP.
  - Set pointer to the id that was not granted.
- WAIT:
  - dp_matrix is held constant.
  - Counter decrements each cycle.
  - When counter==1, capture dp_det and dp_overflow, set error=0, and go to RESP.
- RESP:
  - resp<id>_valid=1 with stable det/overflow/error until resp<id>_ready is high.
  - On that cycle go to IDLE and increment ops_count, wrapping at 2^CNT_W.
  - The other requester's resp outputs stay 0 with valid=0.
  - No new request is accepted until back in IDLE. The earliest next handshake is the cycle after the response handshake.
- Latency: handshake at edge k.
  - Valid size: resp_valid is high from cycle k+DP_LATENCY+1.
  - Invalid size: resp_valid is high from cycle k+1.
- Idle response outputs: resp_det/overflow/error hold the last result; consumers qualify them with valid.
- Requests are not withdrawn by requesters once valid; the scheduler does not depend on this.

Test Plan:
- Size pad: req0 size=2, [[3,1],[2,4]] in rows 0-1 cols 0-1, all other elements 0x7F.
  -> dp_matrix rows/cols 2-4 form identity; resp0_det=10, overflow=0, error=0 at k+3 (DP_LATENCY=2).
- Tie round-robin: both requesters held valid for 4 requests from reset.
  -> grants alternate 0,1,0,1; ready never high for both in the same cycle.
- Overflow: size=5, diag(2).
  -> det=32, overflow=0.
- Overflow wrap: size=5, diag(3).
  -> det=0xF3, overflow=1.
- Invalid size: req1 size=0, then size=6.
  -> resp1_error=1, det=0 at k+1; dp_matrix unchanged from the previous value.
- Backpressure: resp0_ready low for 10 cycles while req1 is valid.
  -> resp0_valid and outputs stable; req1_ready=0 until the cycle after resp0 handshake; ops_count increments once.
- Reset mid-WAIT: assert reset.
  -> next cycle busy=0, all resp_valid=0, dp_matrix=0, ops_count=0; a request issued after reset completes normally.

Source files
------------

// File: rtl/det_scheduler_if.sv
// det_scheduler_if
//   One requester's connection to the determinant scheduler: a request channel
//   (valid/ready plus matrix order and 5x5 element payload) and a response
//   channel (valid/ready plus determinant, overflow and error flags).
//   master : requester side (drives request payload and resp_ready)
//   slave  : scheduler side (drives req_ready and the response payload)
//   Element (r,c) of req_matrix lives at [(5r+c)*W +: W], signed.
interface det_scheduler_if #(
  parameter int W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_size;
  logic [25*W-1:0]   req_matrix;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_det;
  logic              resp_overflow;
  logic              resp_error;

  modport master (
    output req_valid, req_size, req_matrix, resp_ready,
    input  req_ready, resp_valid, resp_det, resp_overflow, resp_error
  );

  modport slave (
    input  req_valid, req_size, req_matrix, resp_ready,
    output req_ready, resp_valid, resp_det, resp_overflow, resp_error
  );
endinterface

// File: rtl/det_scheduler.sv
// det_scheduler
//   Shares one fixed-latency 5x5 determinant datapath between two requesters.
//   Requests are arbitrated round-robin in IDLE; an accepted NxN matrix
//   (N=1..5) is padded to 5x5 with identity and presented on dp_matrix, the
//   scheduler waits DP_LATENCY cycles, captures dp_det/dp_overflow and
//   returns the result to the granted requester. Sizes 0,6,7 are answered
//   immediately with error=1 and det=0.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   req0, req1        requester channels (det_scheduler_if.slave)
//   dp_matrix         registered datapath input, held while waiting
//   dp_det/overflow   datapath result, valid DP_LATENCY cycles after dp_matrix
//   busy              high whenever the controller is not idle
//   ops_count         completed responses, wraps
module det_scheduler #(
  parameter int DP_LATENCY = 2,
  parameter int W          = 8,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  det_scheduler_if.slave      req0,
  det_scheduler_if.slave      req1,
  output logic [25*W-1:0]     dp_matrix,
  input  logic [W-1:0]        dp_det,
  input  logic                dp_overflow,
  output logic                busy,
  output logic [CNT_W-1:0]    ops_count
);

  localparam int LAT_W = (DP_LATENCY < 2) ? 1 : $clog2(DP_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;       // requester favoured on a tie
  logic              gid_q, gid_d;       // requester owning the current op
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [25*W-1:0]   dpm_q, dpm_d;
  logic [W-1:0]      det_q, det_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ops_q, ops_d;

  // Arbitration: a lone requester wins; on a tie the pointer decides.
  logic              any_valid;
  logic              grant_id;
  logic [2:0]        sel_size;
  logic [25*W-1:0]   sel_matrix;
  logic [25*W-1:0]   pad_matrix;
  logic              size_ok;
  logic              resp_ready_sel;

  assign any_valid  = req0.req_valid | req1.req_valid;
  assign grant_id   = (req0.req_valid & req1.req_valid) ? ptr_q : req1.req_valid;
  assign sel_size   = grant_id ? req1.req_size   : req0.req_size;
  assign sel_matrix = grant_id ? req1.req_matrix : req0.req_matrix;
  assign size_ok    = (sel_size >= 3'd1) && (sel_size <= 3'd5);
  assign resp_ready_sel = gid_q ? req1.resp_ready : req0.resp_ready;

  // Identity padding: keep the top-left NxN block, 1 on the remaining
  // diagonal, 0 elsewhere, so the 5x5 determinant equals the NxN one.
  generate
    for (genvar gi = 0; gi < 25; gi++) begin : g_pad
      localparam int R = gi / 5;
      localparam int C = gi % 5;
      always_comb begin
        if ((sel_size > 3'(R)) && (sel_size > 3'(C))) begin
          pad_matrix[gi*W +: W] = sel_matrix[gi*W +: W];
        end else if (R == C) begin
          pad_matrix[gi*W +: W] = W'(1);
        end else begin
          pad_matrix[gi*W +: W] = '0;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    dpm_d   = dpm_q;
    det_d   = det_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    ops_d   = ops_q;
    case (state_q)
      S_IDLE: begin
        // The granted requester's ready is high whenever any request is
        // present, so any_valid is exactly the handshake condition.
        if (any_valid) begin
          gid_d = grant_id;
          ptr_d = ~grant_id;
          if (size_ok) begin
            dpm_d   = pad_matrix;
            cnt_d   = LAT_W'(DP_LATENCY);
            state_d = S_WAIT;
          end else begin
            det_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          det_d   = dp_det;
          ovf_d   = dp_overflow;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_sel) begin
          ops_d   = ops_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      dpm_q   <= '0;
      det_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      dpm_q   <= dpm_d;
      det_q   <= det_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

  assign req0.req_ready = (state_q == S_IDLE) & req0.req_valid & ~grant_id;
  assign req1.req_ready = (state_q == S_IDLE) & req1.req_valid &  grant_id;

  // Result payload is steered to the owning requester only; the other
  // side reads zero. In IDLE the last owner keeps seeing its last result.
  assign req0.resp_valid    = (state_q == S_RESP) & ~gid_q;
  assign req1.resp_valid    = (state_q == S_RESP) &  gid_q;
  assign req0.resp_det      = gid_q ? '0   : det_q;
  assign req1.resp_det      = gid_q ? det_q : '0;
  assign req0.resp_overflow = ~gid_q & ovf_q;
  assign req1.resp_overflow =  gid_q & ovf_q;
  assign req0.resp_error    = ~gid_q & err_q;
  assign req1.resp_error    =  gid_q & err_q;

  assign dp_matrix = dpm_q;
  assign busy      = (state_q != S_IDLE);
  assign ops_count = ops_q;

endmodule

// File: tb/tb_det_scheduler.sv
// Testbench for det_scheduler: a behavioural datapath (exact determinant of
// dp_matrix, one register stage so results arrive DP_LATENCY cycles after the
// matrix) plus a reference model computing the determinant of the NxN request
// directly, checked per scenario and under randomized traffic.
module tb_det_scheduler;
  localparam int W          = 8;
  localparam int DP_LATENCY = 2;
  localparam int CNT_W      = 16;
  localparam int MW         = 25 * W;

  logic             clk = 1'b0;
  logic             reset;
  logic [MW-1:0]    dp_matrix;
  logic [W-1:0]     dp_det;
  logic             dp_overflow;
  logic             busy;
  logic [CNT_W-1:0] ops_count;

  det_scheduler_if #(.W(W)) req0_if ();
  det_scheduler_if #(.W(W)) req1_if ();

  det_scheduler #(.DP_LATENCY(DP_LATENCY), .W(W), .CNT_W(CNT_W)) dut (
    .clock       (clk),
    .reset       (reset),
    .req0        (req0_if),
    .req1        (req1_if),
    .dp_matrix   (dp_matrix),
    .dp_det      (dp_det),
    .dp_overflow (dp_overflow),
    .busy        (busy),
    .ops_count   (ops_count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            ops_exp  = 0;
  logic [MW-1:0] dpm_model = '0;

  // Exact integer determinant of the top-left nxn block (fraction-free elimination).
  function automatic longint det_of(input logic [MW-1:0] m, input int n);
    longint a[5][5];
    longint prev, t;
    int     sgn, piv;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        a[r][c] = longint'($signed(m[(5*r+c)*W +: W]));
    if (n == 1) return a[0][0];
    prev = 1;
    sgn  = 1;
    for (int k = 0; k < n - 1; k++) begin
      if (a[k][k] == 0) begin
        piv = -1;
        for (int i = k + 1; i < n; i++) if (piv < 0 && a[i][k] != 0) piv = i;
        if (piv < 0) return 0;
        for (int j = 0; j < 5; j++) begin
          t = a[k][j]; a[k][j] = a[piv][j]; a[piv][j] = t;
        end
        sgn = -sgn;
      end
      for (int i = k + 1; i < n; i++)
        for (int j = k + 1; j < n; j++)
          a[i][j] = (a[i][j] * a[k][k] - a[i][k] * a[k][j]) / prev;
      prev = a[k][k];
    end
    return sgn * a[n-1][n-1];
  endfunction

  function automatic logic [MW-1:0] pad_exp(input logic [MW-1:0] m, input int n);
    logic [MW-1:0] p;
    p = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r < n && c < n) p[(5*r+c)*W +: W] = m[(5*r+c)*W +: W];
        else if (r == c)    p[(5*r+c)*W +: W] = W'(1);
    return p;
  endfunction

  function automatic bit out_of_range(input longint d);
    return (d > 127) || (d < -128);
  endfunction

  // Behavioural datapath.
  longint dp_val;
  always @(posedge clk) dp_val <= det_of(dp_matrix, 5);
  assign dp_det      = dp_val[W-1:0];
  assign dp_overflow = out_of_range(dp_val);

  task automatic set_req(input int id, input logic v, input logic [2:0] sz, input logic [MW-1:0] m);
    if (id == 0) begin
      req0_if.req_valid = v; req0_if.req_size = sz; req0_if.req_matrix = m;
    end else begin
      req1_if.req_valid = v; req1_if.req_size = sz; req1_if.req_matrix = m;
    end
  endtask

  task automatic set_rr(input int id, input logic v);
    if (id == 0) req0_if.resp_ready = v; else req1_if.resp_ready = v;
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_if.req_ready : req1_if.req_ready;
  endfunction

  function automatic logic rvalid(input int id);
    return (id == 0) ? req0_if.resp_valid : req1_if.resp_valid;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_req(0, 1'b0, 3'd0, '0); set_req(1, 1'b0, 3'd0, '0);
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    ops_exp   = 0;
    dpm_model = '0;
  endtask

  // Issues one request, waits for its response (hold cycles of backpressure)
  // and consumes it. lat is counted in negedges after the handshake edge.
  task automatic run_op(input int id, input logic [2:0] sz, input logic [MW-1:0] m, input int hold,
                        output int lat, output logic [W-1:0] det, output logic ovf, output logic err,
                        output logic [MW-1:0] dpm, output bit stable, output bit ok);
    int n;
    ok = 1; stable = 1; lat = -1; det = '0; ovf = 0; err = 0; dpm = '0;
    @(negedge clk);
    set_req(id, 1'b1, sz, m);
    #1;
    n = 0;
    while (!rdy(id)) begin
      @(negedge clk); #1; n++;
      if (n > 50) begin ok = 0; break; end
    end
    if (!ok) begin set_req(id, 1'b0, 3'd0, '0); return; end
    @(posedge clk);
    @(negedge clk);
    set_req(id, 1'b0, sz, m);
    n = 1;
    while (!rvalid(id) && n < 50) begin @(negedge clk); n++; end
    if (!rvalid(id)) begin ok = 0; return; end
    lat = n;
    det = (id == 0) ? req0_if.resp_det      : req1_if.resp_det;
    ovf = (id == 0) ? req0_if.resp_overflow : req1_if.resp_overflow;
    err = (id == 0) ? req0_if.resp_error    : req1_if.resp_error;
    dpm = dp_matrix;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rvalid(id) || dpm !== dp_matrix ||
          det !== ((id == 0) ? req0_if.resp_det : req1_if.resp_det)) stable = 0;
    end
    set_rr(id, 1'b1);
    @(posedge clk);
    ops_exp++;
    @(negedge clk);
    set_rr(id, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 3'd0, '0); set_req(1, 1'b0, 3'd0, '0);
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (ops_count !== '0) begin n_fail++; $display("FAIL reset_ops: got %0d expected 0", ops_count); end
    n_checks++; if (dp_matrix !== '0) begin n_fail++; $display("FAIL reset_dpm: got %h expected 0", dp_matrix); end
    n_checks++; if ({req0_if.req_ready, req1_if.req_ready, req0_if.resp_valid, req1_if.resp_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 0000",
        {req0_if.req_ready, req1_if.req_ready, req0_if.resp_valid, req1_if.resp_valid}); end
    n_checks++; if ({req0_if.resp_det, req0_if.resp_overflow, req0_if.resp_error,
                     req1_if.resp_det, req1_if.resp_overflow, req1_if.resp_error} !== '0) begin
      n_fail++; $display("FAIL reset_resp_payload: got nonzero det0=%h det1=%h expected 0",
        req0_if.resp_det, req1_if.resp_det); end
    $display("test_reset done: busy=%b ops=%0d", busy, ops_count);
  endtask

  task automatic test_size_pad();
    logic [MW-1:0] m, dpm;
    logic [W-1:0]  det;
    logic          ovf, err;
    int            lat;
    bit            st, ok;
    for (int i = 0; i < 25; i++) m[i*W +: W] = 8'h7F;
    m[0*W +: W] = 8'd3; m[1*W +: W] = 8'd1; m[5*W +: W] = 8'd2; m[6*W +: W] = 8'd4;
    run_op(0, 3'd2, m, 0, lat, det, ovf, err, dpm, st, ok);
    dpm_model = pad_exp(m, 2);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pad_timeout: no handshake/response"); end
    n_checks++; if (dpm !== dpm_model) begin n_fail++; $display("FAIL pad_dpm: got %h expected %h", dpm, dpm_model); end
    n_checks++; if ({det, ovf, err} !== {8'd10, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL pad_result: got det=%0d ovf=%b err=%b expected 10 0 0", det, ovf, err); end
    n_checks++; if (lat !== DP_LATENCY + 1) begin n_fail++; $display("FAIL pad_latency: got %0d expected %0d", lat, DP_LATENCY + 1); end
    $display("test_size_pad: det=%0d ovf=%b err=%b lat=%0d", det, ovf, err, lat);
  endtask

  task automatic test_round_robin();
    logic [MW-1:0] m0, m1;
    int grants[$];
    int resps, cyc;
    do_reset();
    m0 = '0; m0[W-1:0] = 8'd5;
    m1 = '0; m1[W-1:0] = 8'hFD;
    @(negedge clk);
    set_req(0, 1'b1, 3'd1, m0); set_req(1, 1'b1, 3'd1, m1);
    set_rr(0, 1'b1); set_rr(1, 1'b1);
    resps = 0; cyc = 0;
    while (resps < 4 && cyc < 200) begin
      if (grants.size() == 4) begin set_req(0, 1'b0, 3'd1, m0); set_req(1, 1'b0, 3'd1, m1); end
      #1;
      n_checks++; if (req0_if.req_ready && req1_if.req_ready) begin
        n_fail++; $display("FAIL rr_both_ready: got 11 expected at most one"); end
      if (grants.size() < 4) begin
        if (req0_if.req_ready) grants.push_back(0);
        else if (req1_if.req_ready) grants.push_back(1);
      end
      if (req0_if.resp_valid) begin
        resps++; ops_exp++;
        n_checks++; if (req0_if.resp_det !== 8'd5) begin n_fail++; $display("FAIL rr_det0: got %h expected 05", req0_if.resp_det); end
      end
      if (req1_if.resp_valid) begin
        resps++; ops_exp++;
        n_checks++; if (req1_if.resp_det !== 8'hFD) begin n_fail++; $display("FAIL rr_det1: got %h expected fd", req1_if.resp_det); end
      end
      @(negedge clk);
      cyc++;
    end
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    dpm_model = pad_exp(m1, 1);
    n_checks++; if (grants.size() != 4 || resps != 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants %0d resps expected 4 4", grants.size(), resps); end
    for (int i = 0; i < grants.size(); i++) begin
      n_checks++; if (grants[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grants[i], i % 2); end
    end
    n_checks++; if (ops_count !== CNT_W'(ops_exp)) begin n_fail++; $display("FAIL rr_ops: got %0d expected %0d", ops_count, ops_exp); end
    $display("test_round_robin: %0d grants, ops=%0d", grants.size(), ops_count);
  endtask

  task automatic test_overflow();
    logic [MW-1:0] m, dpm;
    logic [W-1:0]  det;
    logic          ovf, err;
    int            lat;
    bit            st, ok;
    for (int v = 2; v <= 3; v++) begin
      m = '0;
      for (int i = 0; i < 5; i++) m[(6*i)*W +: W] = W'(v);
      run_op(0, 3'd5, m, 0, lat, det, ovf, err, dpm, st, ok);
      dpm_model = pad_exp(m, 5);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: diag(%0d)", v); end
      n_checks++; if ({det, ovf, err} !== ((v == 2) ? {8'd32, 1'b0, 1'b0} : {8'hF3, 1'b1, 1'b0})) begin
        n_fail++; $display("FAIL ovf_diag%0d: got det=%h ovf=%b err=%b expected %s", v, det, ovf, err,
          (v == 2) ? "20 0 0" : "f3 1 0"); end
      $display("test_overflow diag(%0d): det=%h ovf=%b", v, det, ovf);
    end
  endtask

  task automatic test_invalid();
    logic [MW-1:0] m, dpm;
    logic [W-1:0]  det;
    logic          ovf, err;
    int            lat;
    bit            st, ok;
    logic [2:0]    sizes[3];
    sizes[0] = 3'd0; sizes[1] = 3'd6; sizes[2] = 3'd7;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) m[i*W +: W] = W'($urandom);
      run_op(1, sizes[k], m, 0, lat, det, ovf, err, dpm, st, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL inv_timeout: size %0d", sizes[k]); end
      n_checks++; if ({det, ovf, err} !== {8'd0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL inv_result: size %0d got det=%h ovf=%b err=%b expected 00 0 1", sizes[k], det, ovf, err); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL inv_latency: size %0d got %0d expected 1", sizes[k], lat); end
      n_checks++; if (dpm !== dpm_model) begin n_fail++; $display("FAIL inv_dpm: size %0d got %h expected %h", sizes[k], dpm, dpm_model); end
      $display("test_invalid size=%0d: err=%b det=%h lat=%0d", sizes[k], err, det, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] m0, m1;
    logic [W-1:0]  det0, exp1;
    int            ops0, n;
    m0 = '0; m1 = '0;
    for (int i = 0; i < 25; i++) begin m0[i*W +: W] = W'(int'($urandom_range(0, 15)) - 8); m1[i*W +: W] = W'($urandom); end
    m1[0*W +: W] = 8'd7; m1[1*W +: W] = 8'd2; m1[5*W +: W] = 8'd3; m1[6*W +: W] = 8'd5;
    exp1 = 8'd29;
    @(negedge clk);
    set_req(0, 1'b1, 3'd3, m0);
    #1;
    n = 0;
    while (!req0_if.req_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 3'd3, m0);
    n = 0;
    while (!req0_if.resp_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++; if (!req0_if.resp_valid) begin n_fail++; $display("FAIL bp_timeout: resp0_valid never rose"); end
    det0 = req0_if.resp_det;
    n_checks++; if (det0 !== W'(det_of(m0, 3))) begin n_fail++; $display("FAIL bp_det: got %h expected %h", det0, W'(det_of(m0, 3))); end
    ops0 = int'(ops_count);
    set_req(1, 1'b1, 3'd2, m1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks++; if (!req0_if.resp_valid || req0_if.resp_det !== det0 || req1_if.req_ready || req1_if.resp_valid) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid0=%b det0=%h ready1=%b valid1=%b expected 1 %h 0 0", i,
          req0_if.resp_valid, req0_if.resp_det, req1_if.req_ready, req1_if.resp_valid, det0); end
    end
    set_rr(0, 1'b1);
    #1;
    n_checks++; if (req1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_early: got %b expected 0", req1_if.req_ready); end
    @(posedge clk);
    ops_exp++;
    @(negedge clk);
    set_rr(0, 1'b0);
    #1;
    n_checks++; if (req1_if.req_ready !== 1'b1 || req0_if.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_after: got ready1=%b valid0=%b expected 1 0", req1_if.req_ready, req0_if.resp_valid); end
    n_checks++; if (ops_count !== CNT_W'(ops0 + 1)) begin n_fail++; $display("FAIL bp_ops: got %0d expected %0d", ops_count, ops0 + 1); end
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 3'd2, m1);
    dpm_model = pad_exp(m1, 2);
    n = 0;
    while (!req1_if.resp_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++; if (req1_if.resp_det !== exp1 || ops_count !== CNT_W'(ops0 + 1)) begin
      n_fail++; $display("FAIL bp_second: got det=%h ops=%0d expected %h %0d", req1_if.resp_det, ops_count, exp1, ops0 + 1); end
    set_rr(1, 1'b1);
    @(posedge clk);
    ops_exp++;
    @(negedge clk);
    set_rr(1, 1'b0);
    $display("test_backpressure: det0=%h det1=%h ops=%0d", det0, exp1, ops_count);
  endtask

  task automatic test_reset_mid_wait();
    logic [MW-1:0] m, dpm;
    logic [W-1:0]  det;
    logic          ovf, err;
    int            lat, n, seen;
    bit            st, ok;
    m = '0;
    for (int i = 0; i < 25; i++) m[i*W +: W] = W'(int'($urandom_range(0, 15)) - 8);
    @(negedge clk);
    set_req(0, 1'b1, 3'd4, m);
    #1;
    n = 0;
    while (!req0_if.req_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ops_exp = 0; dpm_model = '0;
    n_checks++; if (busy !== 1'b0 || req0_if.resp_valid !== 1'b0 || req1_if.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_state: got busy=%b v0=%b v1=%b expected 0 0 0", busy, req0_if.resp_valid, req1_if.resp_valid); end
    n_checks++; if (dp_matrix !== '0 || ops_count !== '0) begin
      n_fail++; $display("FAIL rst_wait_regs: got dpm=%h ops=%0d expected 0 0", dp_matrix, ops_count); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (req0_if.resp_valid || busy) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_wait_dropped: got %0d active cycles expected 0", seen); end
    run_op(0, 3'd4, m, 1, lat, det, ovf, err, dpm, st, ok);
    dpm_model = pad_exp(m, 4);
    n_checks++; if (!ok || det !== W'(det_of(m, 4)) || ovf !== out_of_range(det_of(m, 4)) || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_after: got det=%h ovf=%b err=%b expected %h %b 0", det, ovf, err,
        W'(det_of(m, 4)), out_of_range(det_of(m, 4))); end
    n_checks++; if (ops_count !== CNT_W'(1)) begin n_fail++; $display("FAIL rst_wait_ops: got %0d expected 1", ops_count); end
    $display("test_reset_mid_wait: post-reset det=%h ops=%0d", det, ops_count);
  endtask

  task automatic test_random();
    logic [MW-1:0] m, dpm;
    logic [W-1:0]  det;
    logic          ovf, err;
    int            lat, id, n, hold;
    logic [2:0]    sz;
    longint        d;
    bit            st, ok;
    for (int t = 0; t < 40; t++) begin
      id   = int'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 7));
      hold = int'($urandom_range(0, 3));
      n    = int'(sz);
      for (int i = 0; i < 25; i++)
        m[i*W +: W] = ((i / 5) < n && (i % 5) < n) ? W'(int'($urandom_range(0, 15)) - 8) : W'($urandom);
      run_op(id, sz, m, hold, lat, det, ovf, err, dpm, st, ok);
      n_checks++;
      if (sz >= 3'd1 && sz <= 3'd5) begin
        d = det_of(m, n);
        dpm_model = pad_exp(m, n);
        if (!ok || {det, ovf, err} !== {W'(d), out_of_range(d), 1'b0} || lat !== DP_LATENCY + 1 || dpm !== dpm_model || !st) begin
          n_fail++; $display("FAIL rand[%0d] id=%0d N=%0d: got det=%h ovf=%b err=%b lat=%0d st=%b expected %h %b 0 %0d 1",
            t, id, n, det, ovf, err, lat, st, W'(d), out_of_range(d), DP_LATENCY + 1); end
      end else begin
        if (!ok || {det, ovf, err} !== {8'd0, 1'b0, 1'b1} || lat !== 1 || dpm !== dpm_model || !st) begin
          n_fail++; $display("FAIL rand[%0d] id=%0d size=%0d: got det=%h ovf=%b err=%b lat=%0d st=%b expected 00 0 1 1 1",
            t, id, n, det, ovf, err, lat, st); end
      end
      n_checks++; if (ops_count !== CNT_W'(ops_exp)) begin
        n_fail++; $display("FAIL rand_ops[%0d]: got %0d expected %0d", t, ops_count, ops_exp); end
      $display("rand[%0d] id=%0d size=%0d det=%h ovf=%b err=%b lat=%0d", t, id, n, det, ovf, err, lat);
    end
  endtask

  initial begin
    test_reset();
    test_size_pad();
    test_round_robin();
    test_overflow();
    test_invalid();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
